// File: rtl/switch_input_conditioner.sv
// Slide-switch front end: per-bit 2-flop synchronizer and debounce counter, followed by
// change pulses, sticky change flags and a saturating change-event counter.
module switch_input_conditioner #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    input  logic             clear_changes,
    output logic [WIDTH-1:0] switches_clean,
    output logic [WIDTH-1:0] switch_changed,
    output logic [WIDTH-1:0] sticky_changed,
    output logic             any_change,
    output logic [15:0]      event_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] changed_nxt;

    // Each bit counts consecutive mismatch cycles; any agreement restarts the count.
    always_comb begin
        clean_nxt   = switches_clean;
        changed_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != switches_clean[i]) begin
                if (cnt[i] == LAST) begin
                    clean_nxt[i]   = sync2[i];
                    changed_nxt[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1          <= '0;
            sync2          <= '0;
            switches_clean <= '0;
            switch_changed <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1          <= switches_raw;
            sync2          <= sync1;
            switches_clean <= clean_nxt;
            switch_changed <= changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign any_change = |switch_changed;

    // A change pulse coinciding with a clear survives it, for flags and counter alike.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky_changed <= '0;
            event_count    <= '0;
        end else begin
            sticky_changed <= (clear_changes ? '0 : sticky_changed) | switch_changed;
            if (clear_changes) begin
                event_count <= any_change ? 16'd1 : 16'd0;
            end else if (any_change && (event_count != 16'hFFFF)) begin
                event_count <= event_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Bench for switch_input_conditioner: one instance with DEBOUNCE_CYCLES=4, one with 1,
// both tracked by a behavioural model of the switch/debounce/event rules.
module tb_switch_input_conditioner;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] raw_a, raw_b;
    logic        clr_a, clr_b;
    logic [17:0] clean_a, chg_a, sticky_a, clean_b, chg_b, sticky_b;
    logic        any_a, any_b;
    logic [15:0] ec_a, ec_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    switch_input_conditioner #(.WIDTH(18), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .switches_raw(raw_a), .clear_changes(clr_a),
        .switches_clean(clean_a), .switch_changed(chg_a), .sticky_changed(sticky_a),
        .any_change(any_a), .event_count(ec_a)
    );

    switch_input_conditioner #(.WIDTH(18), .DEBOUNCE_CYCLES(1), .CNT_W(16)) dut_b (
        .clock(clock), .reset(reset), .switches_raw(raw_b), .clear_changes(clr_b),
        .switches_clean(clean_b), .switch_changed(chg_b), .sticky_changed(sticky_b),
        .any_change(any_b), .event_count(ec_b)
    );

    // Reference model: raw levels reach the debouncer through a two-sample delay line;
    // a bit is accepted once it has disagreed with the clean level for dc straight samples.
    int          dc [2] = '{4, 1};
    logic [17:0] m_delay [2][$];
    logic [17:0] m_clean [2];
    logic [17:0] m_pulse [2];
    logic [17:0] m_sticky[2];
    int          m_ec    [2];
    int          m_run   [2][18];

    always @(posedge clock or negedge reset) begin : model
        logic [17:0] seen, np, raw;
        logic        clr, any;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_delay[k]  = {18'h0, 18'h0};
                m_clean[k]  = '0;
                m_pulse[k]  = '0;
                m_sticky[k] = '0;
                m_ec[k]     = 0;
                for (int i = 0; i < 18; i++) m_run[k][i] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                raw  = (k == 0) ? raw_a : raw_b;
                clr  = (k == 0) ? clr_a : clr_b;
                seen = m_delay[k].pop_front();
                m_delay[k].push_back(raw);
                any  = (m_pulse[k] != 0);
                if (clr) m_ec[k] = any ? 1 : 0;
                else if (any) m_ec[k] = (m_ec[k] + 1 > 65535) ? 65535 : m_ec[k] + 1;
                m_sticky[k] = (clr ? 18'h0 : m_sticky[k]) | m_pulse[k];
                np = '0;
                for (int i = 0; i < 18; i++) begin
                    if (seen[i] != m_clean[k][i]) begin
                        m_run[k][i]++;
                        if (m_run[k][i] >= dc[k]) begin
                            m_clean[k][i] = seen[i];
                            np[i]         = 1'b1;
                            m_run[k][i]   = 0;
                        end
                    end else begin
                        m_run[k][i] = 0;
                    end
                end
                m_pulse[k] = np;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({clean_a, chg_a, sticky_a, any_a, ec_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got clean=%h chg=%h sticky=%h any=%b ec=%h required all 0",
                     clean_a, chg_a, sticky_a, any_a, ec_a);
        end
        checks++;
        if ({clean_b, chg_b, sticky_b, any_b, ec_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got clean=%h chg=%h sticky=%h any=%b ec=%h required all 0",
                     clean_b, chg_b, sticky_b, any_b, ec_b);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_rise();
        raw_a = 18'h00001;
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (clean_a !== 18'h0) begin
                errors++;
                $display("FAIL single_early edge %0d: clean=%h required 00000", e, clean_a);
            end
        end
        step();
        checks++;
        if (clean_a !== 18'h00001 || chg_a !== 18'h00001 || any_a !== 1'b1) begin
            errors++;
            $display("FAIL single_edge6: clean=%h chg=%h any=%b required 00001 00001 1",
                     clean_a, chg_a, any_a);
        end
        step();
        checks++;
        if (chg_a !== 18'h0 || sticky_a !== 18'h00001 || ec_a !== 16'd1) begin
            errors++;
            $display("FAIL single_after: chg=%h sticky=%h ec=%h required 00000 00001 0001",
                     chg_a, sticky_a, ec_a);
        end
    endtask

    task automatic test_glitch();
        raw_a[5] = 1'b1;
        repeat (3) step();
        raw_a[5] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (clean_a !== 18'h00001 || chg_a !== 18'h0) begin
                errors++;
                $display("FAIL glitch cycle %0d: clean=%h chg=%h required 00001 00000",
                         c, clean_a, chg_a);
            end
        end
        checks++;
        if (ec_a !== 16'd1) begin
            errors++;
            $display("FAIL glitch_count: ec=%h required 0001", ec_a);
        end
    endtask

    task automatic test_simultaneous();
        raw_a = raw_a | 18'h00204;
        repeat (5) step();
        checks++;
        if (any_a !== 1'b0 || clean_a !== 18'h00001) begin
            errors++;
            $display("FAIL simul_early: any=%b clean=%h required 0 00001", any_a, clean_a);
        end
        step();
        checks++;
        if (clean_a !== 18'h00205 || chg_a !== 18'h00204 || any_a !== 1'b1) begin
            errors++;
            $display("FAIL simul_edge: clean=%h chg=%h any=%b required 00205 00204 1",
                     clean_a, chg_a, any_a);
        end
        step();
        checks++;
        if (any_a !== 1'b0 || ec_a !== 16'd2) begin
            errors++;
            $display("FAIL simul_after: any=%b ec=%h required 0 0002", any_a, ec_a);
        end
    endtask

    task automatic test_clear_collision();
        raw_a[3] = 1'b1;
        repeat (6) step();
        checks++;
        if (chg_a !== 18'h00008) begin
            errors++;
            $display("FAIL collide_pulse: chg=%h required 00008", chg_a);
        end
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        checks++;
        if (sticky_a !== 18'h00008 || ec_a !== 16'd1) begin
            errors++;
            $display("FAIL collide_clear: sticky=%h ec=%h required 00008 0001", sticky_a, ec_a);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) raw_a[$urandom_range(0, 17)] ^= 1'b1;
            if ($urandom_range(0, 2) == 0) raw_b[$urandom_range(0, 17)] ^= 1'b1;
            clr_a = ($urandom_range(0, 15) == 0);
            clr_b = ($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (clean_a !== m_clean[0] || chg_a !== m_pulse[0] || sticky_a !== m_sticky[0] ||
                any_a !== (m_pulse[0] != 0) || ec_a !== 16'(m_ec[0])) begin
                errors++;
                $display("FAIL random_a cycle %0d: got %h %h %h %b %h required %h %h %h %h",
                         c, clean_a, chg_a, sticky_a, any_a, ec_a,
                         m_clean[0], m_pulse[0], m_sticky[0], 16'(m_ec[0]));
            end
            checks++;
            if (clean_b !== m_clean[1] || chg_b !== m_pulse[1] || sticky_b !== m_sticky[1] ||
                any_b !== (m_pulse[1] != 0) || ec_b !== 16'(m_ec[1])) begin
                errors++;
                $display("FAIL random_b cycle %0d: got %h %h %h %b %h required %h %h %h %h",
                         c, clean_b, chg_b, sticky_b, any_b, ec_b,
                         m_clean[1], m_pulse[1], m_sticky[1], 16'(m_ec[1]));
            end
        end
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    task automatic test_saturation();
        int bad = 0;
        for (int c = 0; c < 65600; c++) begin
            raw_b[0] = ~raw_b[0];
            step();
            checks++;
            if (ec_b !== 16'(m_ec[1])) begin
                errors++;
                if (bad < 5)
                    $display("FAIL sat_track cycle %0d: ec=%h required %h", c, ec_b, 16'(m_ec[1]));
                bad++;
            end
        end
        checks++;
        if (ec_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_top: ec=%h required FFFF", ec_b);
        end
        repeat (10) step();
        checks++;
        if (ec_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: ec=%h required FFFF", ec_b);
        end
    endtask

    task automatic test_reset_mid();
        raw_a = 18'h0;
        repeat (10) step();
        raw_a[7] = 1'b1;
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({clean_a, chg_a, sticky_a, any_a, ec_a, clean_b, sticky_b, ec_b} !== '0) begin
            errors++;
            $display("FAIL async_reset: clean=%h sticky=%h ec=%h ec_b=%h required all 0",
                     clean_a, sticky_a, ec_a, ec_b);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (clean_a !== 18'h0) begin
                errors++;
                $display("FAIL post_reset edge %0d: clean=%h required 00000", e, clean_a);
            end
        end
        step();
        checks++;
        if (clean_a !== 18'h00080 || chg_a !== 18'h00080) begin
            errors++;
            $display("FAIL post_reset_edge6: clean=%h chg=%h required 00080 00080", clean_a, chg_a);
        end
    endtask

    initial begin
        reset = 1'b0;
        raw_a = '0;
        raw_b = '0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        test_reset();
        test_single_rise();
        test_glitch();
        test_simultaneous();
        test_clear_collision();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
